// File: rtl/if_stage_pkg.sv
// Shared definitions for the IF stage and its neighbours: reset PC and
// inter-stage bus widths/field offsets (also used by the decode stage).
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  localparam int unsigned FS_TO_DS_BUS_W = 64;
  localparam int unsigned BR_BUS_W       = 33;

  // fs_to_ds_bus = {inst, pc}
  localparam int unsigned FS_PC_LSB   = 0;
  localparam int unsigned FS_INST_LSB = 32;

  // br_collect = {br_taken, br_target}
  localparam int unsigned BR_TARGET_LSB = 0;
  localparam int unsigned BR_TAKEN_BIT  = 32;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF request generation plus IF register, single
// outstanding SRAM-like request. Optional counters under FETCH_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ds_allowin,
  input  logic [BR_BUS_W-1:0]       br_collect,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_cnt,
  output logic [31:0]               cancel_cnt
`endif
);

  logic        resetn_q;
  logic [31:0] pf_pc;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_wait;
  logic        cancel;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;
  logic [31:0] br_buf;
  logic        br_buf_valid;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        accept;
  logic        handoff;
  logic        data_live;
  logic        capture;

  assign br_taken  = br_collect[BR_TAKEN_BIT];
  assign br_target = br_collect[BR_TARGET_LSB +: 32];

  always_comb begin
    nextpc = pf_pc + 32'd4;
    if (br_taken)          nextpc = br_target;
    else if (br_buf_valid) nextpc = br_buf;
  end

  assign data_live      = fs_wait & inst_sram_data_ok & ~cancel;
  assign fs_ready_go    = data_live | inst_buf_valid;
  assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go;
  assign handoff        = fs_to_ds_valid & ds_allowin;
  assign capture        = data_live & ~ds_allowin;

  assign inst_sram_req   = resetn_q & fs_allowin & ~cancel;
  assign accept          = inst_sram_req & inst_sram_addr_ok;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;

  assign fs_to_ds_bus[FS_INST_LSB +: 32] = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_bus[FS_PC_LSB +: 32]   = fs_pc;

  always_ff @(posedge clk) resetn_q <= resetn;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pf_pc          <= RESET_PC - 32'd4;
      fs_valid       <= 1'b0;
      fs_pc          <= '0;
      fs_wait        <= 1'b0;
      cancel         <= 1'b0;
      inst_buf       <= '0;
      inst_buf_valid <= 1'b0;
      br_buf         <= '0;
      br_buf_valid   <= 1'b0;
    end else begin
      if (accept) begin
        pf_pc    <= nextpc;
        fs_pc    <= nextpc;
        fs_valid <= 1'b1;
      end else if (handoff || br_taken) begin
        fs_valid <= 1'b0;
      end

      if (accept)                            fs_wait <= 1'b1;
      else if (fs_wait && inst_sram_data_ok) fs_wait <= 1'b0;

      // Only arm cancel while the response is still outstanding; a response
      // arriving in the redirect cycle is consumed (or dropped) right here.
      if (cancel && inst_sram_data_ok)                      cancel <= 1'b0;
      else if (br_taken && fs_wait && !inst_sram_data_ok)   cancel <= 1'b1;

      if (capture) inst_buf <= inst_sram_rdata;
      if (br_taken || handoff) inst_buf_valid <= 1'b0;
      else if (capture)        inst_buf_valid <= 1'b1;

      if (br_taken && !accept) begin
        br_buf       <= br_target;
        br_buf_valid <= 1'b1;
      end else if (accept) begin
        br_buf_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic dropped;

  // Late cancelled response, wrong-path response in the redirect cycle, or
  // a held instruction killed by the redirect; these never coincide.
  assign dropped = (cancel & inst_sram_data_ok)
                 | (br_taken & ~handoff & (capture | inst_buf_valid));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      if (handoff) fetch_cnt  <= fetch_cnt + 32'd1;
      if (dropped) cancel_cnt <= cancel_cnt + 32'd1;
    end
  end
`endif

endmodule
